// File: rtl/fp_add_pkg.sv
// Shared FP32 types and operand classification for the FP32 adder issue stage.
package fp_add_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_cls_e;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    function automatic fp_cls_e fp_classify(input fp32_t x);
        fp_cls_e cls;
        if (x.exp == 8'h00) begin
            cls = (x.man == 23'd0) ? ZERO : SUB;
        end else if (x.exp == EXP_MAX) begin
            cls = (x.man == 23'd0) ? INF : NAN;
        end else begin
            cls = NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_pair_fifo.sv
// Synchronous FIFO holding operand pairs; exposes occupancy as level.
module fp_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_issue.sv
// Issue stage for the FP32 adder: buffers pairs, drives op_1/op_2/en, delays special-result flags.
// Optional FP_ADD_FTZ_EN: subnormal operands are flushed to signed zero at issue.
module fp_add_issue
    import fp_add_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDER_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_op_1,
    input  logic [31:0]              in_op_2,
    input  logic                     issue_stall,
    output logic [31:0]              op_1,
    output logic [31:0]              op_2,
    output logic                     en,
    input  logic                     val,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     flag_valid,
    output logic                     flag_nan,
    output logic                     flag_inf,
    output logic                     sync_err
);

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid.
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [63:0] head;
    logic [31:0] iss_1;
    logic [31:0] iss_2;

    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !issue_stall;

    fp_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ({in_op_1, in_op_2}),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

`ifdef FP_ADD_FTZ_EN
    assign iss_1 = (fp_classify(fp32_t'(head[63:32])) == SUB) ? {head[63], 31'd0} : head[63:32];
    assign iss_2 = (fp_classify(fp32_t'(head[31:0]))  == SUB) ? {head[31], 31'd0} : head[31:0];
`else
    assign iss_1 = head[63:32];
    assign iss_2 = head[31:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            op_1 <= '0;
            op_2 <= '0;
            en   <= 1'b0;
        end else if (pop) begin
            op_1 <= iss_1;
            op_2 <= iss_2;
            en   <= 1'b1;
        end else begin
            en   <= 1'b0;
        end
    end

    // Flags are classified from the issued operands, so flushed subnormals count as zero.
    fp_cls_e cls_1;
    fp_cls_e cls_2;
    logic    nan_now;
    logic    inf_now;

    assign cls_1   = fp_classify(fp32_t'(op_1));
    assign cls_2   = fp_classify(fp32_t'(op_2));
    assign nan_now = en && ((cls_1 == NAN) || (cls_2 == NAN) ||
                            ((cls_1 == INF) && (cls_2 == INF) && (op_1[31] != op_2[31])));
    assign inf_now = en && !nan_now && ((cls_1 == INF) || (cls_2 == INF));

    // Each stage is {valid, nan, inf}; the last stage lines up with the adder's val.
    logic [2:0] dly [ADDER_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ADDER_LAT; i++) dly[i] <= 3'b000;
        end else begin
            dly[0] <= {en, nan_now, inf_now};
            for (int i = 1; i < ADDER_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign flag_valid = dly[ADDER_LAT-1][2];
    assign flag_nan   = dly[ADDER_LAT-1][1];
    assign flag_inf   = dly[ADDER_LAT-1][0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= sync_err | (val ^ flag_valid);
        end
    end

endmodule
